// File: rtl/ssd1331_power_sequencer.sv
`timescale 1ns/1ps
// Power-up/power-down sequencer for an SSD1331 OLED panel: drives the supply and
// reset pins, streams the init command list, then forwards user bytes to the SPI transmitter.
module ssd1331_power_sequencer #(
    parameter int PWR_DLY    = 20,
    parameter int RES_CYCLES = 4,
    parameter int VCC_DLY    = 20
) (
    input  logic       i_SCK,
    input  logic       i_RST,
    input  logic       i_TX_VALID,
    input  logic [7:0] i_TX_DATA,
    input  logic       i_TX_DC,
    output logic       o_TX_READY,
    input  logic       i_PWR_DOWN,
    input  logic       i_SPI_CS,
    input  logic       i_SPI_FINAL_TX,
    output logic       o_SPI_START,
    output logic [7:0] o_SPI_DATA,
    output logic       o_SPI_DC,
    output logic       o_PMODEN,
    output logic       o_RES_N,
    output logic       o_VCCEN,
    output logic       o_READY
);

    localparam int PWR_EFF = (PWR_DLY < 1) ? 1 : PWR_DLY;
    localparam int RES_EFF = (RES_CYCLES < 1) ? 1 : RES_CYCLES;
    localparam int VCC_EFF = (VCC_DLY < 1) ? 1 : VCC_DLY;
    // PWR_WAIT starts counting at reset, so its first edge is the one that raises PMODEN.
    localparam logic [23:0] PWR_LIM = 24'(PWR_EFF);
    localparam logic [23:0] RES_LIM = 24'(RES_EFF - 1);
    localparam logic [23:0] VCC_LIM = 24'(VCC_EFF - 1);

    typedef enum logic [3:0] {
        PWR_WAIT, RES_LOW, RES_HIGH, INIT, VCC_WAIT,
        DISP_ON, READY, PD_CMD, PD_VCC, OFF
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        sent_q, sent_d;
    logic        tx_ok, bus_idle, issue, iss_dc, vccen_d;
    logic [7:0]  iss_data;

    function automatic logic [7:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:  init_byte = 8'hAE;  4'd1:  init_byte = 8'hA0;
            4'd2:  init_byte = 8'h72;  4'd3:  init_byte = 8'hA1;
            4'd4:  init_byte = 8'h00;  4'd5:  init_byte = 8'hA2;
            4'd6:  init_byte = 8'h00;  4'd7:  init_byte = 8'hA4;
            4'd8:  init_byte = 8'hA8;  4'd9:  init_byte = 8'h3F;
            4'd10: init_byte = 8'hAD;  4'd11: init_byte = 8'h8E;
            4'd12: init_byte = 8'hB0;  4'd13: init_byte = 8'h0B;
            4'd14: init_byte = 8'h87;  default: init_byte = 8'h06;
        endcase
    endfunction

    // Handshake: a user byte transfers on a posedge where i_TX_VALID and o_TX_READY are
    // both high; i_TX_VALID may be held across bytes, o_TX_READY never depends on it.
    assign tx_ok      = (i_SPI_CS | i_SPI_FINAL_TX) & ~o_SPI_START;
    assign bus_idle   = i_SPI_CS & ~o_SPI_START;
    assign o_READY    = (state_q == READY);
    assign o_TX_READY = (state_q == READY) & tx_ok & ~i_PWR_DOWN;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sent_d   = sent_q;
        issue    = 1'b0;
        iss_data = 8'h00;
        iss_dc   = 1'b0;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LIM) begin
                    state_d = RES_LOW;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 24'd1;
            end
            RES_LOW: begin
                if (cnt_q == RES_LIM) begin
                    state_d = RES_HIGH;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 24'd1;
            end
            RES_HIGH: begin
                // The edge that ends a wait also launches the first byte of the next state.
                if (cnt_q == RES_LIM) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    idx_d   = 5'd0;
                    if (tx_ok) begin
                        issue    = 1'b1;
                        iss_data = init_byte(4'd0);
                        idx_d    = 5'd1;
                    end
                end else cnt_d = cnt_q + 24'd1;
            end
            INIT: begin
                if (idx_q[4]) begin
                    if (bus_idle) begin
                        state_d = VCC_WAIT;
                        cnt_d   = '0;
                    end
                end else if (tx_ok) begin
                    issue    = 1'b1;
                    iss_data = init_byte(idx_q[3:0]);
                    idx_d    = idx_q + 5'd1;
                end
            end
            VCC_WAIT: begin
                if (cnt_q == VCC_LIM) begin
                    state_d = DISP_ON;
                    cnt_d   = '0;
                    sent_d  = 1'b0;
                    if (tx_ok) begin
                        issue    = 1'b1;
                        iss_data = 8'hAF;
                        sent_d   = 1'b1;
                    end
                end else cnt_d = cnt_q + 24'd1;
            end
            DISP_ON: begin
                if (sent_q) begin
                    if (bus_idle) state_d = READY;
                end else if (tx_ok) begin
                    issue    = 1'b1;
                    iss_data = 8'hAF;
                    sent_d   = 1'b1;
                end
            end
            READY: begin
                if (i_PWR_DOWN) begin
                    state_d = PD_CMD;
                    sent_d  = 1'b0;
                end else if (i_TX_VALID && tx_ok) begin
                    issue    = 1'b1;
                    iss_data = i_TX_DATA;
                    iss_dc   = i_TX_DC;
                end
            end
            PD_CMD: begin
                if (sent_q) begin
                    if (bus_idle) begin
                        state_d = PD_VCC;
                        cnt_d   = '0;
                    end
                end else if (tx_ok) begin
                    issue    = 1'b1;
                    iss_data = 8'hAE;
                    sent_d   = 1'b1;
                end
            end
            PD_VCC: begin
                if (cnt_q == VCC_LIM) state_d = OFF;
                else cnt_d = cnt_q + 24'd1;
            end
            OFF:     ;
            default: state_d = PWR_WAIT;
        endcase
    end

    assign vccen_d = (state_d == VCC_WAIT) || (state_d == DISP_ON) ||
                     (state_d == READY) || (state_d == PD_CMD);

    always_ff @(posedge i_SCK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            sent_q      <= 1'b0;
            o_SPI_START <= 1'b0;
            o_SPI_DATA  <= 8'h00;
            o_SPI_DC    <= 1'b0;
            o_PMODEN    <= 1'b0;
            o_RES_N     <= 1'b1;
            o_VCCEN     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sent_q      <= sent_d;
            o_SPI_START <= issue;
            if (issue) begin
                o_SPI_DATA <= iss_data;
                o_SPI_DC   <= iss_dc;
            end
            o_PMODEN <= (state_d != OFF);
            o_RES_N  <= (state_d != RES_LOW);
            o_VCCEN  <= vccen_d;
        end
    end

endmodule

// File: tb/tb_ssd1331_power_sequencer.sv
`timescale 1ns/1ps
// Bench for ssd1331_power_sequencer: timeline tables for power-up/power-down plus a
// bit-serial transmitter model whose decoded bytes are scored against an expected queue.
module tb_ssd1331_power_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0, tx_dc = 1'b0, pwr_down = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       o_TX_READY, o_SPI_START, o_SPI_DC, o_PMODEN, o_RES_N, o_VCCEN, o_READY;
    logic [7:0] o_SPI_DATA;
    logic       cs_q, final_tx;

    int n_vec = 0, n_err = 0, cyc = 0, n_starts = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ssd1331_power_sequencer #(.PWR_DLY(4), .RES_CYCLES(3), .VCC_DLY(5)) dut (
        .i_SCK(clk), .i_RST(rst),
        .i_TX_VALID(tx_valid), .i_TX_DATA(tx_data), .i_TX_DC(tx_dc), .o_TX_READY(o_TX_READY),
        .i_PWR_DOWN(pwr_down), .i_SPI_CS(cs_q), .i_SPI_FINAL_TX(final_tx),
        .o_SPI_START(o_SPI_START), .o_SPI_DATA(o_SPI_DATA), .o_SPI_DC(o_SPI_DC),
        .o_PMODEN(o_PMODEN), .o_RES_N(o_RES_N), .o_VCCEN(o_VCCEN), .o_READY(o_READY)
    );

    // Transmitter model: loads on START, shifts MSB first one bit per clock; the
    // receiver side rebuilds each byte from the serial bit stream.
    logic [7:0] sh_q, rx_q;
    logic [2:0] bit_q;
    logic       dc_q;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    assign final_tx = ~cs_q & (bit_q == 3'd7);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q <= 1'b1; sh_q <= 8'h00; rx_q <= 8'h00; bit_q <= 3'd0; dc_q <= 1'b0;
        end else if (o_SPI_START) begin
            cs_q <= 1'b0; sh_q <= o_SPI_DATA; dc_q <= o_SPI_DC; bit_q <= 3'd0;
        end else if (!cs_q) begin
            rx_q  <= {rx_q[6:0], sh_q[7]};
            sh_q  <= {sh_q[6:0], 1'b0};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                cs_q <= 1'b1;
                got_q.push_back({dc_q, rx_q[6:0], sh_q[7]});
            end
        end
    end

    logic prev_start = 1'b0;
    always @(posedge clk) begin
        if (o_SPI_START) begin
            n_starts++;
            n_vec++;
            if (prev_start) begin
                n_err++;
                $display("FAIL start_gap: START high two cycles in a row at cycle %0d", cyc);
            end
        end
        prev_start <= o_SPI_START;
    end

    // Timeline records: inputs applied at the checkpoint, then outputs compared.
    // flags = {PMODEN, RES_N, VCCEN, READY, TX_READY, SPI_START}
    typedef struct {
        int         cyc;
        logic       valid;
        logic       pd;
        logic [5:0] flags;
        logic       chk_data;
        logic [7:0] data;
    } vec_t;
    vec_t tab[$];

    logic [7:0] init_rom [17] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
                                  8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'h87, 8'h06, 8'hAF};

    function automatic void add(input int c, input logic v, input logic p,
                                input logic [5:0] f, input logic cd, input logic [7:0] d);
        vec_t e;
        e.cyc = c; e.valid = v; e.pd = p; e.flags = f; e.chk_data = cd; e.data = d;
        tab.push_back(e);
    endfunction

    function automatic void fill_powerup();
        tab.delete();
        add(0,   1, 1, 6'b010000, 1, 8'h00);
        add(1,   1, 1, 6'b110000, 0, 8'h00);
        add(4,   1, 1, 6'b110000, 0, 8'h00);
        add(5,   1, 1, 6'b100000, 0, 8'h00);
        add(7,   1, 1, 6'b100000, 0, 8'h00);
        add(8,   1, 1, 6'b110000, 0, 8'h00);
        add(10,  1, 1, 6'b110000, 0, 8'h00);
        add(11,  1, 1, 6'b110001, 1, 8'hAE);
        add(12,  1, 1, 6'b110000, 1, 8'hAE);
        add(20,  1, 1, 6'b110001, 1, 8'hA0);
        add(146, 1, 1, 6'b110001, 1, 8'h06);
        add(155, 1, 1, 6'b110000, 0, 8'h00);
        add(156, 1, 1, 6'b111000, 0, 8'h00);
        add(160, 1, 1, 6'b111000, 0, 8'h00);
        add(161, 1, 1, 6'b111001, 1, 8'hAF);
        add(170, 0, 0, 6'b111000, 0, 8'h00);
        add(171, 0, 0, 6'b111110, 0, 8'h00);
    endfunction

    function automatic void fill_powerdown();
        tab.delete();
        add(0,  1, 1, 6'b111100, 0, 8'h00);
        add(1,  1, 1, 6'b111000, 0, 8'h00);
        add(2,  1, 1, 6'b111001, 1, 8'hAE);
        add(3,  1, 1, 6'b111000, 0, 8'h00);
        add(11, 1, 1, 6'b111000, 0, 8'h00);
        add(12, 1, 1, 6'b110000, 0, 8'h00);
        add(16, 1, 1, 6'b110000, 0, 8'h00);
        add(17, 1, 1, 6'b010000, 0, 8'h00);
        add(40, 1, 1, 6'b010000, 0, 8'h00);
    endfunction

    task automatic run_table(input string tag);
        int cur;
        logic [5:0] f;
        cur = 0;
        foreach (tab[i]) begin
            repeat (tab[i].cyc - cur) @(posedge clk);
            cur = tab[i].cyc;
            #1;
            tx_valid = tab[i].valid;
            pwr_down = tab[i].pd;
            #1;
            f = {o_PMODEN, o_RES_N, o_VCCEN, o_READY, o_TX_READY, o_SPI_START};
            n_vec++;
            if (f !== tab[i].flags) begin
                n_err++;
                $display("FAIL %s_flags cyc %0d: got %b want %b", tag, tab[i].cyc, f, tab[i].flags);
            end
            if (tab[i].chk_data) begin
                n_vec++;
                if ({o_SPI_DC, o_SPI_DATA} !== {1'b0, tab[i].data}) begin
                    n_err++;
                    $display("FAIL %s_data cyc %0d: got dc=%b %h want dc=0 %h",
                             tag, tab[i].cyc, o_SPI_DC, o_SPI_DATA, tab[i].data);
                end
            end
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [8:0] g, e;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count: got %0d bytes want %0d", tag, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s_byte: got dc=%b %h want dc=%b %h", tag, g[8], g[7:0], e[8], e[7:0]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_user(input logic [7:0] b, output int acc);
        bit done;
        done = 1'b0;
        acc = 0;
        tx_data = b; tx_dc = 1'b1; tx_valid = 1'b1;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (o_TX_READY) begin
                @(posedge clk);
                #1;
                acc = cyc;
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL accept_%h: got no accept within 200 cycles, want accept", b);
        end
    endtask

    task automatic reset_release();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int a0, a1, a2, s0;
        logic [8:0] user_b [3];
        user_b = '{9'h15A, 9'h1C3, 9'h1FF};

        reset_release();
        fill_powerup();
        run_table("pwrup");
        foreach (init_rom[i]) exp_q.push_back({1'b0, init_rom[i]});
        check_bytes("init");

        send_user(8'h5A, a0);
        send_user(8'hC3, a1);
        send_user(8'hFF, a2);
        tx_valid = 1'b0;
        n_vec++;
        if (a1 - a0 != 9) begin n_err++; $display("FAIL user_gap1: got %0d want 9", a1 - a0); end
        n_vec++;
        if (a2 - a1 != 9) begin n_err++; $display("FAIL user_gap2: got %0d want 9", a2 - a1); end
        repeat (12) @(posedge clk);
        foreach (user_b[i]) exp_q.push_back(user_b[i]);
        check_bytes("user");

        s0 = n_starts;
        tx_data = 8'h77; tx_dc = 1'b1;
        fill_powerdown();
        run_table("pwrdn");
        n_vec++;
        if (n_starts - s0 != 1) begin
            n_err++;
            $display("FAIL pd_starts: got %0d starts want 1", n_starts - s0);
        end
        exp_q.push_back({1'b0, 8'hAE});
        check_bytes("pd");

        // Reset while the 8th init byte is on the wire.
        reset_release();
        tx_valid = 1'b0; pwr_down = 1'b0;
        repeat (78) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_PMODEN, o_RES_N, o_VCCEN, o_READY, o_TX_READY, o_SPI_START, o_SPI_DC, o_SPI_DATA}
            !== {6'b010000, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset: got %b %b %h want 010000 0 00",
                     {o_PMODEN, o_RES_N, o_VCCEN, o_READY, o_TX_READY, o_SPI_START}, o_SPI_DC, o_SPI_DATA);
        end
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, init_rom[i]});
        check_bytes("partial");

        reset_release();
        fill_powerup();
        run_table("restart");
        foreach (init_rom[i]) exp_q.push_back({1'b0, init_rom[i]});
        check_bytes("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ssd1331_power_sequencer.md
SSD1331_POWER_SEQUENCER -- requirements
Module: ssd1331_power_sequencer

Interface
REQ-001 SHALL have parameter PWR_DLY, default 20, meaning i_SCK cycles from PMODEN high to RES_N low.
REQ-002 SHALL have parameter RES_CYCLES, default 4, meaning i_SCK cycles RES_N is held low, and then held high before the first command.
REQ-003 SHALL have parameter VCC_DLY, default 20, meaning i_SCK cycles from VCCEN high to display-on, and from VCCEN low to PMODEN low; delay counter 24 bits.
REQ-004 SHALL have ports, in this order:
 i_SCK  in  1  clock; all logic on posedge.
 i_RST  in  1  reset; asynchronous, active-high.
 i_TX_VALID  in  1  user byte request.
 i_TX_DATA  in  8  user byte.
 i_TX_DC  in  1  user D/C bit (0=command, 1=data).
 o_TX_READY  out  1  user byte accepted when high with i_TX_VALID.
 i_PWR_DOWN  in  1  power-down request, honoured only in READY.
 i_SPI_CS  in  1  transmitter chip select (high = idle).
 i_SPI_FINAL_TX  in  1  transmitter next-bit-is-last flag.
 o_SPI_START  out  1  one-cycle byte start pulse to transmitter.
 o_SPI_DATA  out  8  byte to transmitter.
 o_SPI_DC  out  1  D/C bit to transmitter.
 o_PMODEN  out  1  panel logic supply enable.
 o_RES_N  out  1  panel reset, active-low.
 o_VCCEN  out  1  panel VCC enable.
 o_READY  out  1  high only in READY state.

Function
REQ-005 SHALL define tx_ok = (i_SPI_CS | i_SPI_FINAL_TX) & ~o_SPI_START.
REQ-006 SHALL issue a byte at a posedge only when tx_ok: register o_SPI_START=1 for exactly one cycle, load o_SPI_DATA/o_SPI_DC; o_SPI_DATA/o_SPI_DC hold until next issue.
REQ-007 SHALL never assert o_SPI_START in consecutive cycles, nor while tx_ok is low.
REQ-008 SHALL implement states PWR_WAIT, RES_LOW, RES_HIGH, INIT, VCC_WAIT, DISP_ON, READY, PD_CMD, PD_VCC, OFF.
REQ-009 PWR_WAIT: o_PMODEN=1 from first posedge after reset release; after PWR_DLY cycles -> RES_LOW.
REQ-010 RES_LOW: o_RES_N=0 for RES_CYCLES cycles -> RES_HIGH; RES_HIGH: o_RES_N=1 for RES_CYCLES cycles -> INIT.
REQ-011 INIT: issue 16 command bytes (DC=0) in order AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B 87 06, one per tx_ok opportunity; after 16th issue and i_SPI_CS high -> VCC_WAIT.
REQ-012 VCC_WAIT: o_VCCEN=1; after VCC_DLY cycles -> DISP_ON.
REQ-013 DISP_ON: issue AF (DC=0); after issue and i_SPI_CS high -> READY.
REQ-014 READY: o_READY=1; o_TX_READY = tx_ok & ~i_PWR_DOWN (combinational); i_TX_VALID & o_TX_READY at posedge issues i_TX_DATA/i_TX_DC per REQ-006.
REQ-015 READY with i_PWR_DOWN=1 (priority over i_TX_VALID, also when simultaneous) -> PD_CMD; in-flight byte completes.
REQ-016 PD_CMD: issue AE (DC=0); after issue and i_SPI_CS high -> PD_VCC with o_VCCEN=0.
REQ-017 PD_VCC: after VCC_DLY cycles o_PMODEN=0 -> OFF; OFF is terminal until i_RST.
REQ-018 o_TX_READY SHALL be 0 in every state except READY; i_TX_VALID outside READY SHALL be ignored, no byte issued.
REQ-019 i_PWR_DOWN outside READY SHALL be ignored (not latched).
REQ-020 Delay counters SHALL reload at each state entry; a parameter of 0 SHALL behave as 1 cycle.

Reset
REQ-021 While i_RST high, asynchronously: state PWR_WAIT, counters 0, o_SPI_START=0, o_SPI_DATA=00, o_SPI_DC=0, o_PMODEN=0, o_RES_N=1, o_VCCEN=0, o_READY=0, o_TX_READY=0.
REQ-022 i_RST mid-operation (any state, mid-byte) SHALL abort immediately to REQ-021 values and restart the full sequence on release.

Verification (PWR_DLY=4, RES_CYCLES=3, VCC_DLY=5, 8-bit transmitter model attached)
REQ-023 Reset release -> PMODEN=1 next posedge; RES_N low exactly 3 cycles starting 4 cycles later; first START 3 cycles after RES_N rises, data AE.
REQ-024 Full init -> MOSI stream decodes 16 init bytes then AF, all DC=0, back-to-back via FINAL_TX; VCCEN rises before AF, READY after AF completes.
REQ-025 READY, i_TX_VALID held with 3 bytes (DC=1) 5A C3 FF -> three accepts, bytes decoded in order with DC=1, no START gap beyond tx_ok.
REQ-026 READY, i_PWR_DOWN and i_TX_VALID same cycle -> o_TX_READY=0, AE issued, VCCEN falls, PMODEN falls 5 cycles later, state OFF; later i_TX_VALID ignored.
REQ-027 i_RST pulsed during 8th init byte -> outputs at reset values at once; sequence restarts and reissues AE first.
